// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited memory requests feeding a prefetch FIFO,
// with redirect handling that drains and discards stale in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];

    logic          grant, push, pop, resp_ok;
    logic [CW:0]   credit_used;
    logic [CW-1:0] remaining;
    logic [31:0]   resp_pc;
    logic [31:0]   redirect_aligned;

    assign mem_addr    = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = fifo_data[rd_ptr_q];
    assign instr_pc    = fifo_pc[rd_ptr_q];

    // Requests since the last redirect are contiguous, so the oldest one in
    // flight sits exactly outst_q words behind fetch_pc.
    assign resp_pc          = fetch_pc_q - (32'(outst_q) << 2);
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        outst_d     = outst_q;
        discard_d   = discard_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;

        credit_used = {1'b0, count_q} + {1'b0, outst_q};
        resp_ok     = mem_rvalid && (outst_q != '0);
        mem_req     = rst && (state_q == RUN) && !redirect && (credit_used < DEPTH_C);
        grant       = mem_req && mem_gnt;
        push        = (state_q == RUN) && resp_ok && !redirect;
        pop         = instr_valid && instr_ready && !redirect;
        remaining   = outst_q - CW'(resp_ok);

        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_aligned;
                    outst_d    = '0;
                    if (remaining != '0) begin
                        discard_d = remaining;
                        state_d   = DRAIN;
                    end
                end else begin
                    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
                    outst_d = outst_q + CW'(grant) - CW'(resp_ok);
                end
            end
            DRAIN: begin
                if (redirect) fetch_pc_d = redirect_aligned;
                if (mem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
                if (discard_d == '0) state_d = RUN;
            end
        endcase

        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= mem_rdata;
            fifo_pc[wr_ptr_q]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based memory returns addr ^ KEY one
// cycle or more after grant; a second instance covers address wrap-around.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst, redirect, mem_gnt, mem_rvalid, instr_ready;
    logic [31:0] redirect_pc, mem_rdata;
    logic        mem_req, instr_valid;
    logic [31:0] mem_addr, instr, instr_pc;

    logic        rst_w, w_rvalid;
    logic [31:0] w_rdata;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;

    logic        resp_en;
    logic [31:0] pend[$];
    logic [31:0] w_pend[$];
    int          grants;
    int          total  = 0;
    int          passed = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
        .clk(clk), .rst(rst_w), .redirect(1'b0), .redirect_pc(32'h0),
        .mem_req(w_req), .mem_addr(w_addr), .mem_gnt(1'b1),
        .mem_rvalid(w_rvalid), .mem_rdata(w_rdata),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc),
        .instr_ready(1'b1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle starting and ending at a falling edge; memory responses
    // are presented before the rising edge, grants are recorded at it.
    task automatic tick();
        logic        g, wg;
        logic [31:0] ga, wga;
        if (resp_en && pend.size() > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend.pop_front() ^ KEY;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        if (w_pend.size() > 0) begin
            w_rvalid = 1'b1;
            w_rdata  = w_pend.pop_front() ^ KEY;
        end else begin
            w_rvalid = 1'b0;
            w_rdata  = 32'h0;
        end
        #1;
        g   = mem_req && mem_gnt;
        ga  = mem_addr;
        wg  = w_req;
        wga = w_addr;
        @(posedge clk);
        if (g) begin
            pend.push_back(ga);
            grants++;
        end
        if (wg) w_pend.push_back(wga);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        redirect   = 1'b0;
        mem_rvalid = 1'b0;
        pend.delete();
        #1;
        check("rst_async_valid", instr_valid, 1'b0);
        check("rst_async_req", mem_req, 1'b0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; rst_w = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b0;
        w_rvalid = 1'b0; w_rdata = 32'h0; resp_en = 1'b0; grants = 0;

        // Reset state and first request after release
        @(negedge clk);
        tick();
        check("reset_valid", instr_valid, 1'b0);
        check("reset_req", mem_req, 1'b0);
        check("reset_addr", mem_addr, 32'h0);
        rst = 1'b1;
        #1;
        check("first_req", mem_req, 1'b1);
        check("first_addr", mem_addr, 32'h0);

        // Streaming: one instruction per cycle after a two-cycle fill
        mem_gnt = 1'b1; instr_ready = 1'b1; resp_en = 1'b1;
        tick(); check("stream_fill", instr_valid, 1'b0);
        tick(); check("stream_pc0", instr_pc, 32'h0);
                check("stream_instr0", instr, 32'h1357_9BDF);
        tick(); check("stream_pc4", instr_pc, 32'h4);
        tick(); check("stream_pc8", instr_pc, 32'h8);
        tick(); check("stream_pcC", instr_pc, 32'hC);

        // Reset mid-stream, then back-pressure fills the FIFO to DEPTH
        grants = 0;
        do_reset();
        instr_ready = 1'b0;
        repeat (5) tick();
        check("bp_head_mid", instr_pc, 32'h0);
        repeat (5) tick();
        check("bp_grants", grants, 4);
        check("bp_req_off", mem_req, 1'b0);
        check("bp_valid", instr_valid, 1'b1);
        check("bp_head_end", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick(); check("bp_pop_4", instr_pc, 32'h4);
        tick(); check("bp_pop_8", instr_pc, 32'h8);
        tick(); check("bp_pop_C", instr_pc, 32'hC);
                check("bp_instr_C", instr, 32'h1357_9BD3);

        // Redirect with three outstanding requests, unaligned target
        do_reset();
        resp_en = 1'b0;
        repeat (3) tick();
        check("out3_addr", mem_addr, 32'hC);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        check("redir_req_off", mem_req, 1'b0);
        tick();
        redirect = 1'b0;
        #1;
        check("redir_flushed", instr_valid, 1'b0);
        check("drain_req_off", mem_req, 1'b0);
        resp_en = 1'b1;
        tick(); tick();
        check("drain_still", mem_req, 1'b0);
        tick();
        check("drain_done_req", mem_req, 1'b1);
        check("drain_done_addr", mem_addr, 32'h100);
        check("drain_no_stale", instr_valid, 1'b0);
        tick(); tick();
        check("after_drain_pc", instr_pc, 32'h100);
        check("after_drain_instr", instr, 32'h1357_9ADF);

        // Redirect to 0x200, then again to 0x300 while draining
        resp_en = 1'b0;
        tick();
        grants = 0;
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300; resp_en = 1'b1;
        tick();
        check("dd_flushed", instr_valid, 1'b0);
        redirect = 1'b0;
        tick();
        check("dd_no_fetch", grants, 0);
        check("dd_req", mem_req, 1'b1);
        check("dd_addr", mem_addr, 32'h300);
        tick(); tick();
        check("dd_pc", instr_pc, 32'h300);

        // Redirect in the same cycle as a response and a pop
        redirect = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        #1;
        check("same_flushed", instr_valid, 1'b0);
        check("same_no_drain", mem_req, 1'b1);
        check("same_addr", mem_addr, 32'h400);
        tick(); tick();
        check("same_pc", instr_pc, 32'h400);
        check("same_instr", instr, 32'h1357_9FDF);

        // Fetch address wraps past the top of the address space
        rst_w = 1'b1;
        #1;
        check("wrap_first_req", w_req, 1'b1);
        check("wrap_first_addr", w_addr, 32'hFFFF_FFF8);
        tick(); tick();
        check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc2", w_pc, 32'h0000_0000);
        check("wrap_instr2", w_instr, 32'h1357_9BDF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset (word-aligned).
REQ-002 Parameter DEPTH, default 4: prefetch FIFO entries and max outstanding memory requests (power of 2, >=2).
REQ-003 clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-005 redirect  input  1  core requests refetch from redirect_pc (taken branch/jump).
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0.
REQ-007 mem_req  output  1  instruction-memory read request valid.
REQ-008 mem_addr  output  32  word-aligned read address; [1:0] always 0.
REQ-009 mem_gnt  input  1  request accepted this cycle when mem_req=1.
REQ-010 mem_rvalid  input  1  read data valid; responses return in grant order, earliest 1 cycle after grant.
REQ-011 mem_rdata  input  32  read data.
REQ-012 instr_valid  output  1  FIFO head holds a valid instruction.
REQ-013 instr  output  32  instruction word at FIFO head.
REQ-014 instr_pc  output  32  address of instr.
REQ-015 instr_ready  input  1  core consumes head this cycle when instr_valid=1.

Function
REQ-016 State machine states RUN and DRAIN; reset state RUN.
REQ-017 fetch_pc register holds next address to request; mem_addr = fetch_pc.
REQ-018 Credit rule: mem_req = 1 only in RUN, redirect=0, and (fifo_count + outstanding) < DEPTH; FIFO shall never overflow.
REQ-019 Grant (mem_req & mem_gnt): fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), outstanding += 1.
REQ-020 Response in RUN: {mem_rdata, address of that request} pushed to FIFO tail next edge, outstanding -= 1; instr_valid rises the cycle after mem_rvalid.
REQ-021 Pop on instr_valid & instr_ready; simultaneous push and pop legal at any occupancy, count unchanged.
REQ-022 instr/instr_pc shall be stable while instr_valid=1 and instr_ready=0.
REQ-023 mem_req/mem_addr held stable until granted, except withdrawn by redirect.
REQ-024 Redirect in RUN: fetch_pc <= {redirect_pc[31:2],2'b00}; FIFO cleared; any pop that cycle ignored; grant that cycle impossible (mem_req=0).
REQ-025 Redirect with outstanding responses remaining after the current cycle: discard counter <= that number; go to DRAIN; else stay RUN.
REQ-026 DRAIN: mem_req=0; each mem_rvalid decrements discard counter, data dropped; return to RUN on edge where counter reaches 0.
REQ-027 Redirect in DRAIN: fetch_pc updated again, stay DRAIN, counter unaffected except same-cycle response decrement.
REQ-028 mem_rvalid with outstanding = 0 is a protocol error; ignored, no state change.
REQ-029 outstanding and discard counters width clog2(DEPTH)+1, never underflow.

Reset
REQ-030 While rst=0: state RUN, fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, instr_valid=0, mem_req=0.
REQ-031 First cycle after rst rises: mem_req=1, mem_addr=RESET_PC.
REQ-032 Reset assertion mid-operation discards all in-flight and buffered data; responses to pre-reset grants are the memory's responsibility to abort.

Verification
REQ-033 Reset release, mem_gnt=1, 1-cycle response, instr_ready=1 -> instr_pc sequence 0,4,8,... one per cycle after 2-cycle fill.
REQ-034 instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 grants, mem_req=0 afterward, FIFO holds PCs 0..12 in order, no loss.
REQ-035 3 requests outstanding, redirect_pc=0x103 -> FIFO empty, DRAIN drops 3 responses, next mem_addr=0x100, first instr_pc=0x100.
REQ-036 Redirect in DRAIN to 0x200 then 0x300 -> only 0x300 fetched after drain completes.
REQ-037 Redirect same cycle as mem_rvalid and pop -> response dropped, discard count excludes it, no stale instr delivered.
REQ-038 RESET_PC=0xFFFF_FFF8 -> instr_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
